rv_bus_arbiter: RTL and testbench
=================================

# rv_bus_arbiter

Two-master, one-slave transaction arbiter for the RV32I multi-cycle system bus. It sits between the CPU data port (load/store issued from the memory-access states) and a second master (DMA/boot loader), and serialises their accesses onto a single RAM/peripheral slave port. Arbitration is round-robin. Transfers use an APB-style setup/access sequence with slave wait states. An optional watchdog aborts stalled transfers.

## Interface
- ADDR_W, 32: address width for masters and slave
- DATA_W, 32: data width
- TIMEOUT, 16: ACCESS-state cycles before abort; only used with BUS_ARB_TIMEOUT_EN; legal range 2..255
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- m0_req / m1_req  in  1  transfer request; held until the matching mN_ready
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_we / m1_we  in  1  1 = store, 0 = load
- m0_wdata / m1_wdata  in  DATA_W  store data
- m0_mode / m1_mode  in  3  funct3 size code (SB/SH/SW, LB/LH/LW/LBU/LHU)
- m0_rdata / m1_rdata  out  DATA_W  load data; valid only while mN_ready=1
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  abort flag; valid with mN_ready
- s_sel  out  1  slave select (setup + access)
- s_en  out  1  slave enable (access phase)
- s_addr, s_we, s_wdata, s_mode  out  ADDR_W/1/DATA_W/3  latched transfer attributes
- s_rdata  in  DATA_W  slave read data
- s_ready  in  1  slave completion, sampled only in ACCESS
- grant  out  2  one-hot owner of the current transfer; 00 when idle

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: choose a winner, latch its addr/we/wdata/mode into the s_* registers, set grant, go to SETUP.
- **Arbitration**
  - One requester: it wins.
  - Both requesting: the master that was not served last wins.
  - The last-served pointer updates on entry to SETUP.
  - Pointer reset value is 1, so m0 wins the first tie.
- **SETUP**: s_sel=1, s_en=0. Unconditionally go to ACCESS.
- **ACCESS**
  - s_sel=1, s_en=1.
  - s_ready=0: remain in ACCESS (wait state).
  - s_ready=1: register s_rdata into the response register and go to RESP.
- **RESP**
  - Granted master's mN_ready=1 for exactly one cycle. mN_rdata carries the registered data for loads and 0 for stores.
  - The non-granted master sees ready=0 and rdata=0.
  - Unconditionally go to IDLE; grant clears on that transition.
- **Master rule**
  - A master drops or updates mN_req at the clock edge where it samples mN_ready=1.
  - Requests arriving during SETUP/ACCESS/RESP are not lost; they are sampled in the next IDLE cycle.
- **Attributes**: s_* outputs are held constant from SETUP through ACCESS. Master-side input changes after latching are ignored.
- **Reset values**: state=IDLE, grant=00, s_sel=s_en=s_we=0, s_addr=s_wdata=0, s_mode=0, mN_ready=mN_err=0, mN_rdata=0, pointer=1.

## Timing
- Minimum latency, zero wait states: req high in cycle 0 → SETUP cycle 1 → ACCESS cycle 2 (s_ready=1) → mN_ready in cycle 3.
- Each slave wait cycle adds one cycle.
- Back-to-back transfers: IDLE occupies one cycle between transfers, so peak throughput is one transfer per 4 cycles.
- Both masters continuously requesting: grants strictly alternate (m0, m1, m0, …).
- Reset asserted mid-transfer: all outputs fall to their reset values asynchronously. The aborted transfer gets no ready pulse, and the slave sees s_sel drop immediately.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with s_ready=0.
  - When the count reaches TIMEOUT-1 with s_ready still 0, the FSM goes to RESP with mN_err=1 and rdata=0.
  - s_ready=1 in the same cycle as the terminal count counts as a normal completion: err=0.
- Not defined: counter is absent, ACCESS waits indefinitely, and m0_err/m1_err are tied to 0.

## Structure
- Shared package bus_pkg holds:
  - the state_e enum (IDLE, SETUP, ACCESS, RESP);
  - funct3 mode constants for the load/store sizes, identical to the encodings the control unit drives on L_mode/S_mode.
- One sub-module, bus_rr_pick: combinational two-way round-robin winner select from {m1_req, m0_req} and the last-served pointer; outputs a one-hot winner.
- The FSM, latches, response register and timeout counter stay in rv_bus_arbiter.

## Test plan
- **Single load**: m0 reads 0x0000_0010, slave returns 0xDEAD_BEEF with zero wait states → m0_ready in cycle 3 with m0_rdata=0xDEAD_BEEF; grant=01 during cycles 1–3.
- **Tie**: m0 and m1 request together from reset, both held → served in order m0, m1, m0; grant sequence 01, 10, 01.
- **Wait states**: m1 stores 0x1234_5678 to 0x100 with s_ready delayed 5 cycles → s_addr/s_wdata stable throughout; m1_ready in cycle 8; m0_ready stays 0.
- **Timeout**, BUS_ARB_TIMEOUT_EN with TIMEOUT=4: slave never asserts s_ready → m0_ready=1 and m0_err=1 after 4 ACCESS cycles; FSM back in IDLE on the next cycle.
- **Reset mid-ACCESS**: reset asserted during cycle 2 of a transfer → s_sel, s_en and grant are 0 in the same cycle; no ready pulse; after release, a new m1 request completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the RV32I system bus: arbiter FSM states and funct3 size codes.
// Mode codes match what the control unit drives on L_mode/S_mode.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/bus_rr_pick.sv
// Two-way round-robin winner select; purely combinational.
// On a tie the master that was not served last wins (last=1 means m1 was last).
module bus_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/rv_bus_arbiter.sv
// Two-master round-robin arbiter onto one APB-style slave; 3 cycles req->ready plus slave waits.
// Optional ACCESS watchdog under BUS_ARB_TIMEOUT_EN aborts stalled transfers with mN_err.
module rv_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_mode,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_mode,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              m1_err,
    output logic              s_sel,
    output logic              s_en,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_we,
    output logic [DATA_W-1:0] s_wdata,
    output logic [2:0]        s_mode,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic [1:0]        grant
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("rv_bus_arbiter: TIMEOUT must be in 2..255");
    end

    state_e            state;
    state_e            state_nxt;
    logic [1:0]        win;
    logic              last;
    logic [DATA_W-1:0] rdata_q;
    logic              to_hit;
    logic              resp_err;

    bus_rr_pick u_pick (
        .req  ({m1_req, m0_req}),
        .last (last),
        .win  (win)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] to_cnt;
    logic       err_q;

    // SETUP always precedes ACCESS, so clearing there is "clear on entry".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !s_ready) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    assign to_hit = (state == ACCESS) && !s_ready && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == ACCESS && s_ready) begin
            err_q <= 1'b0;
        end else if (to_hit) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err = err_q;
`else
    assign to_hit   = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win != 2'b00) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (s_ready || to_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, pointer and slave attributes are captured together on leaving IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant   <= 2'b00;
            last    <= 1'b1;
            s_addr  <= '0;
            s_we    <= 1'b0;
            s_wdata <= '0;
            s_mode  <= 3'b000;
        end else if (state == IDLE && win != 2'b00) begin
            grant <= win;
            last  <= win[1];
            if (win[1]) begin
                s_addr  <= m1_addr;
                s_we    <= m1_we;
                s_wdata <= m1_wdata;
                s_mode  <= m1_mode;
            end else begin
                s_addr  <= m0_addr;
                s_we    <= m0_we;
                s_wdata <= m0_wdata;
                s_mode  <= m0_mode;
            end
        end else if (state == RESP) begin
            grant <= 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state == ACCESS && s_ready) begin
            rdata_q <= s_rdata;
        end else if (to_hit) begin
            rdata_q <= '0;
        end
    end

    assign s_sel = (state == SETUP) || (state == ACCESS);
    assign s_en  = (state == ACCESS);

    assign m0_ready = (state == RESP) && grant[0];
    assign m1_ready = (state == RESP) && grant[1];
    assign m0_err   = m0_ready && resp_err;
    assign m1_err   = m1_ready && resp_err;
    // Stores return zero; rdata_q already holds zero after a watchdog abort.
    assign m0_rdata = (m0_ready && !s_we) ? rdata_q : '0;
    assign m1_rdata = (m1_ready && !s_we) ? rdata_q : '0;

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Directed bench for rv_bus_arbiter: load, tie alternation, wait states, watchdog, reset mid-ACCESS.
// Build with BUS_ARB_TIMEOUT_EN defined to exercise the abort path (TIMEOUT=4).
module tb_rv_bus_arbiter;
    import bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [2:0]    m0_mode, m1_mode;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_ready, m1_ready, m0_err, m1_err;
    logic          s_sel, s_en, s_we, s_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [2:0]    s_mode;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_mode(m0_mode), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_mode(m1_mode), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_sel(s_sel), .s_en(s_en), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
        .s_mode(s_mode), .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_addr = '0; m0_we = 0; m0_wdata = '0; m0_mode = F3_W;
        m1_req = 0; m1_addr = '0; m1_we = 0; m1_wdata = '0; m1_mode = F3_W;
        s_ready = 0; s_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  exp_g [3];
        int          exp_c [3];
        logic [31:0] exp_a [3];
        int          n;
        int          rdy_c;
        int          rdy_n;
        logic        stable;
        logic        m0_seen;
        logic [31:0] rd;
        logic        er;
        logic        seen;

        // Reset values
        reset = 1'b1;
        clear_inputs();
        smp();
        chk("rst_grant", grant, 2'b00);
        chk("rst_sel", s_sel, 0);
        chk("rst_en", s_en, 0);
        chk("rst_we", s_we, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_wdata", s_wdata, 0);
        chk("rst_mode", s_mode, 0);
        chk("rst_ready", {m1_ready, m0_ready, m1_err, m0_err}, 0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
        cyc();
        reset = 1'b0;

        // Single zero-wait load by m0
        m0_req = 1; m0_addr = 32'h0000_0010; m0_we = 0; m0_mode = F3_W;
        smp();
        chk("t1_c0_grant", grant, 2'b00);
        chk("t1_c0_sel", s_sel, 0);
        cyc(); smp();
        chk("t1_c1_grant", grant, 2'b01);
        chk("t1_c1_sel_en", {s_sel, s_en}, 2'b10);
        chk("t1_c1_addr", s_addr, 32'h10);
        chk("t1_c1_mode", s_mode, F3_W);
        cyc(); s_ready = 1; s_rdata = 32'hDEAD_BEEF; smp();
        chk("t1_c2_sel_en", {s_sel, s_en}, 2'b11);
        chk("t1_c2_ready", m0_ready, 0);
        cyc(); s_ready = 0; s_rdata = '0; smp();
        chk("t1_c3_ready", m0_ready, 1);
        chk("t1_c3_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t1_c3_err", m0_err, 0);
        chk("t1_c3_grant", grant, 2'b01);
        chk("t1_c3_m1", {m1_ready, m1_rdata}, 0);
        cyc(); m0_req = 0; smp();
        chk("t1_c4_idle", {grant, m0_ready, s_sel}, 0);

        // Tie from reset: m0, m1, m0 at cycles 3, 7, 11
        reset = 1'b1; clear_inputs(); cyc(); reset = 1'b0;
        exp_g = '{2'b01, 2'b10, 2'b01};
        exp_c = '{3, 7, 11};
        exp_a = '{32'h20, 32'h30, 32'h20};
        m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h30;
        s_ready = 1; s_rdata = 32'hA5A5_0000;
        n = 0;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) cyc();
            smp();
            if (m0_ready || m1_ready) begin
                if (n < 3) begin
                    chk("t2_grant", grant, exp_g[n]);
                    chk("t2_cycle", c, exp_c[n]);
                    chk("t2_addr", s_addr, exp_a[n]);
                    chk("t2_rdata", m0_rdata | m1_rdata, 32'hA5A5_0000);
                end
                n++;
            end
        end
        chk("t2_count", n, 3);

        // Store by m1 with 5 wait states; single requester wins although last=1
        reset = 1'b1; clear_inputs(); cyc(); reset = 1'b0;
        m1_req = 1; m1_addr = 32'h100; m1_we = 1; m1_wdata = 32'h1234_5678; m1_mode = F3_W;
        s_rdata = 32'hFFFF_FFFF;
        stable = 1; m0_seen = 0; rdy_c = -1; rd = 32'hBAD0_BAD0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc();
            if (c == 3) begin m1_addr = 32'h200; m1_wdata = '0; end
            if (c == 9) m1_req = 0;
            s_ready = (c == 7);
            smp();
            if (c == 1) chk("t3_grant", grant, 2'b10);
            if (c >= 2 && c <= 7)
                stable &= (s_addr == 32'h100) && (s_wdata == 32'h1234_5678) && s_en && s_we;
            m0_seen |= m0_ready;
            if (m1_ready) begin rdy_c = c; rd = m1_rdata; end
        end
        chk("t3_stable", stable, 1);
        chk("t3_ready_cycle", rdy_c, 8);
        chk("t3_store_rdata", rd, 0);
        chk("t3_m0_quiet", m0_seen, 0);

        // Stalled slave: aborted after 4 ACCESS cycles when the watchdog is built in
        cyc();
        m0_req = 1; m0_addr = 32'h40; m0_we = 0; s_rdata = 32'h0000_0055;
        rdy_c = -1; rdy_n = 0; rd = 32'hBAD0_BAD0; er = 1'bx; seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc();
            if (seen) m0_req = 0;
`ifdef BUS_ARB_TIMEOUT_EN
            s_ready = 0;
`else
            s_ready = (c == 7);
`endif
            smp();
`ifdef BUS_ARB_TIMEOUT_EN
            if (c == 7) chk("t4_c7_idle", {s_sel, grant}, 3'b000);
`else
            if (c == 6) chk("t4_c6_waiting", {s_en, m0_ready, m0_err}, 3'b100);
`endif
            if (m0_ready) begin rdy_c = c; rd = m0_rdata; er = m0_err; rdy_n++; seen = 1; end
        end
`ifdef BUS_ARB_TIMEOUT_EN
        chk("t4_ready_cycle", rdy_c, 6);
        chk("t4_err", er, 1);
        chk("t4_rdata", rd, 0);
`else
        chk("t4_ready_cycle", rdy_c, 8);
        chk("t4_err", er, 0);
        chk("t4_rdata", rd, 32'h55);
`endif
        chk("t4_pulses", rdy_n, 1);

        // Reset during ACCESS, then a clean m1 load
        cyc();
        m0_req = 1; m0_addr = 32'h80; m0_we = 0; s_ready = 0;
        cyc(); cyc();
        chk("t5_pre_access", {s_sel, s_en, grant}, 4'b1101);
        reset = 1'b1;
        #1;
        chk("t5_async_drop", {s_sel, s_en, grant, m0_ready}, 0);
        m0_req = 0;
        m0_seen = 0;
        for (int c = 0; c < 2; c++) begin
            cyc(); smp();
            m0_seen |= m0_ready | m1_ready;
        end
        chk("t5_no_pulse", m0_seen, 0);
        cyc();
        reset = 1'b0;
        m1_req = 1; m1_addr = 32'h300; m1_we = 0; s_ready = 1; s_rdata = 32'hCAFE_F00D;
        cyc(); cyc(); cyc(); smp();
        chk("t5_m1_ready", {m1_ready, m0_ready}, 2'b10);
        chk("t5_m1_rdata", m1_rdata, 32'hCAFE_F00D);
        chk("t5_m1_addr", s_addr, 32'h300);
        cyc(); m1_req = 0; s_ready = 0; smp();
        chk("t5_idle", {grant, m1_ready}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
